// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response and data-bus bundle between the decoder,
//                d_bus and the sequential accumulator ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    localparam int AMTW = $clog2(WIDTH);

    // Request side (decoder -> ALU)
    logic             start;
    logic [2:0]       op;
    logic             dir;
    logic [AMTW-1:0]  amt;
    logic [WIDTH-1:0] din;

    // Response side (ALU -> decoder / d_bus)
    logic [WIDTH-1:0] dout;
    logic             dout_en;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] latch;
    logic             c;
    logic             z;
    logic             busy;
    logic             done;

    modport master (
        output start, op, dir, amt, din,
        input  dout, dout_en, acc, latch, c, z, busy, done
    );

    modport slave (
        input  start, op, dir, amt, din,
        output dout, dout_en, acc, latch, c, z, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : WIDTH-bit accumulator ALU with single-cycle arithmetic/logic
//                ops and multi-cycle SHIFT / shift-add MUL, start/busy/done
//                handshake and an output-enabled result bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  wire logic     tclk,
    input  wire logic     reset,
    alu_seq_if.slave      bus
);
    localparam int AMTW = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [2:0] c_OP_ADD   = 3'b000;
    localparam logic [2:0] c_OP_SUB   = 3'b001;
    localparam logic [2:0] c_OP_NAND  = 3'b010;
    localparam logic [2:0] c_OP_SHIFT = 3'b011;
    localparam logic [2:0] c_OP_LD    = 3'b100;
    localparam logic [2:0] c_OP_ST    = 3'b101;
    localparam logic [2:0] c_OP_MUL   = 3'b110;
    localparam logic [2:0] c_OP_WB    = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    // Architectural state
    state_t             r_state,  w_state_nxt;
    logic [WIDTH-1:0]   r_acc,    w_acc_nxt;
    logic [WIDTH-1:0]   r_latch,  w_latch_nxt;
    logic               r_c,      w_c_nxt;
    logic               r_z,      w_z_nxt;
    logic               r_done,   w_done_nxt;
    logic               r_oe,     w_oe_nxt;

    // Multi-cycle working state (captured at accept)
    logic               r_is_mul, w_is_mul_nxt;
    logic               r_dir,    w_dir_nxt;
    logic [CNTW-1:0]    r_cnt,    w_cnt_nxt;
    logic [WIDTH-1:0]   r_work,   w_work_nxt;
    logic [2*WIDTH-1:0] r_prod,   w_prod_nxt;

    // Combinational datapath results
    logic               w_mul_en;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_nand;
    logic [WIDTH-1:0]   w_sh_work;
    logic               w_sh_bit;
    logic [WIDTH:0]     w_mul_hi;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0]   w_mul_lo;
    logic               w_mul_ovf;

    // With MUL disabled opcode 110 degenerates to a one-cycle NOP
    generate
        if (MUL_EN != 0) begin : g_mul_on
            assign w_mul_en = 1'b1;
        end else begin : g_mul_off
            assign w_mul_en = 1'b0;
        end
    endgenerate

    // Single-cycle arithmetic; the extra MSB carries out the carry / borrow
    assign w_add  = {1'b0, r_acc} + {1'b0, bus.din};
    assign w_sub  = {1'b0, r_acc} - {1'b0, bus.din};
    assign w_nand = ~(r_acc & bus.din);

    // One shift step on the working copy; the bit leaving the word is the carry
    assign w_sh_work = r_dir ? {1'b0, r_work[WIDTH-1:1]} : {r_work[WIDTH-2:0], 1'b0};
    assign w_sh_bit  = r_dir ? r_work[0] : r_work[WIDTH-1];

    // One shift-add step: multiplier sits in the low half and drains out of
    // bit 0 while the partial product grows into the high half
    assign w_mul_hi   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_acc} : '0);
    assign w_mul_prod = {w_mul_hi, r_prod[WIDTH-1:1]};
    assign w_mul_lo   = w_mul_prod[WIDTH-1:0];
    assign w_mul_ovf  = |w_mul_prod[2*WIDTH-1:WIDTH];

    // Output drive
    assign bus.dout    = r_latch;
    assign bus.dout_en = r_oe;
    assign bus.acc     = r_acc;
    assign bus.latch   = r_latch;
    assign bus.c       = r_c;
    assign bus.z       = r_z;
    assign bus.busy    = (r_state == S_EXEC);
    assign bus.done    = r_done;

    // State register and all datapath registers; active-low synchronous reset
    always_ff @(posedge tclk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_latch  <= '0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_done   <= 1'b0;
            r_oe     <= 1'b0;
            r_is_mul <= 1'b0;
            r_dir    <= 1'b0;
            r_cnt    <= '0;
            r_work   <= '0;
            r_prod   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_latch  <= w_latch_nxt;
            r_c      <= w_c_nxt;
            r_z      <= w_z_nxt;
            r_done   <= w_done_nxt;
            r_oe     <= w_oe_nxt;
            r_is_mul <= w_is_mul_nxt;
            r_dir    <= w_dir_nxt;
            r_cnt    <= w_cnt_nxt;
            r_work   <= w_work_nxt;
            r_prod   <= w_prod_nxt;
        end
    end

    // Next-state / next-register logic: accept in IDLE, step and retire in EXEC
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_latch_nxt  = r_latch;
        w_c_nxt      = r_c;
        w_z_nxt      = r_z;
        w_done_nxt   = 1'b0;
        w_oe_nxt     = 1'b0;
        w_is_mul_nxt = r_is_mul;
        w_dir_nxt    = r_dir;
        w_cnt_nxt    = r_cnt;
        w_work_nxt   = r_work;
        w_prod_nxt   = r_prod;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        c_OP_ADD: begin
                            w_latch_nxt = w_add[WIDTH-1:0];
                            w_c_nxt     = w_add[WIDTH];
                            w_z_nxt     = (w_add[WIDTH-1:0] == '0);
                            w_done_nxt  = 1'b1;
                            w_oe_nxt    = 1'b1;
                        end
                        c_OP_SUB: begin
                            w_latch_nxt = w_sub[WIDTH-1:0];
                            w_c_nxt     = w_sub[WIDTH];
                            w_z_nxt     = (w_sub[WIDTH-1:0] == '0);
                            w_done_nxt  = 1'b1;
                            w_oe_nxt    = 1'b1;
                        end
                        c_OP_NAND: begin
                            w_latch_nxt = w_nand;
                            w_c_nxt     = 1'b0;
                            w_z_nxt     = (w_nand == '0);
                            w_done_nxt  = 1'b1;
                            w_oe_nxt    = 1'b1;
                        end
                        c_OP_SHIFT: begin
                            if (bus.amt == '0) begin
                                // Zero distance: pass acc through in one cycle
                                w_latch_nxt = r_acc;
                                w_c_nxt     = 1'b0;
                                w_z_nxt     = (r_acc == '0);
                                w_done_nxt  = 1'b1;
                                w_oe_nxt    = 1'b1;
                            end else begin
                                w_state_nxt  = S_EXEC;
                                w_is_mul_nxt = 1'b0;
                                w_dir_nxt    = bus.dir;
                                w_cnt_nxt    = CNTW'(bus.amt);
                                w_work_nxt   = r_acc;
                            end
                        end
                        c_OP_LD: begin
                            w_acc_nxt  = bus.din;
                            w_done_nxt = 1'b1;
                        end
                        c_OP_ST: begin
                            w_latch_nxt = r_acc;
                            w_done_nxt  = 1'b1;
                            w_oe_nxt    = 1'b1;
                        end
                        c_OP_MUL: begin
                            if (w_mul_en) begin
                                w_state_nxt  = S_EXEC;
                                w_is_mul_nxt = 1'b1;
                                w_cnt_nxt    = CNTW'(WIDTH);
                                w_prod_nxt   = {{WIDTH{1'b0}}, bus.din};
                            end else begin
                                w_done_nxt = 1'b1;
                            end
                        end
                        default: begin
                            // WB
                            w_acc_nxt  = r_latch;
                            w_done_nxt = 1'b1;
                        end
                    endcase
                end
            end

            default: begin
                // S_EXEC: one step per cycle; the step on count 1 retires
                w_cnt_nxt  = r_cnt - 1'b1;
                w_work_nxt = w_sh_work;
                w_prod_nxt = w_mul_prod;
                if (r_cnt == CNTW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_oe_nxt    = 1'b1;
                    if (r_is_mul) begin
                        w_latch_nxt = w_mul_lo;
                        w_c_nxt     = w_mul_ovf;
                        w_z_nxt     = (w_mul_lo == '0);
                    end else begin
                        w_latch_nxt = w_sh_work;
                        w_c_nxt     = w_sh_bit;
                        w_z_nxt     = (w_sh_work == '0);
                    end
                end
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq (WIDTH=8), with a
//                second instance built with MUL disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    logic tclk;
    logic reset;
    int   checks;
    int   errors;

    alu_seq_if #(.WIDTH(8)) bus ();
    alu_seq_if #(.WIDTH(8)) bus2 ();

    alu_seq #(.WIDTH(8), .MUL_EN(1)) u_dut (
        .tclk  (tclk),
        .reset (reset),
        .bus   (bus)
    );

    alu_seq #(.WIDTH(8), .MUL_EN(0)) u_dut_nomul (
        .tclk  (tclk),
        .reset (reset),
        .bus   (bus2)
    );

    initial tclk = 1'b0;
    always #5 tclk = ~tclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge
    task automatic issue(input logic [2:0] o, input logic [7:0] d,
                         input logic dr, input logic [2:0] a);
        bus.start = 1'b1;
        bus.op    = o;
        bus.din   = d;
        bus.dir   = dr;
        bus.amt   = a;
        @(negedge tclk);
        bus.start = 1'b0;
        bus.din   = ~d;
        bus.op    = 3'b100;
        bus.amt   = 3'd7;
    endtask

    // Counts falling edges until done is seen, bounded
    task automatic wait_done(inout int n);
        while (!bus.done && n < 40) begin
            @(negedge tclk);
            n++;
        end
    endtask

    initial begin
        int  n;
        logic saw_done;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.start = 1'b0; bus.op = 3'b0; bus.dir = 1'b0; bus.amt = '0; bus.din = '0;
        bus2.start = 1'b0; bus2.op = 3'b0; bus2.dir = 1'b0; bus2.amt = '0; bus2.din = '0;
        repeat (2) @(posedge tclk);
        @(negedge tclk);
        reset = 1'b1;

        // Reset state
        chk("rst_acc", bus.acc, 8'h00);
        chk("rst_latch", bus.latch, 8'h00);
        chk("rst_c", bus.c, 1'b0);
        chk("rst_z", bus.z, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_oe", bus.dout_en, 1'b0);

        // LD 0xFF then ADD 0x01 wraps to zero with carry
        issue(3'b100, 8'hFF, 1'b0, 3'd0);
        chk("ld_done", bus.done, 1'b1);
        chk("ld_oe", bus.dout_en, 1'b0);
        chk("ld_acc", bus.acc, 8'hFF);
        issue(3'b000, 8'h01, 1'b0, 3'd0);
        chk("add_latch", bus.latch, 8'h00);
        chk("add_c", bus.c, 1'b1);
        chk("add_z", bus.z, 1'b1);
        chk("add_done", bus.done, 1'b1);
        chk("add_busy", bus.busy, 1'b0);
        chk("add_oe", bus.dout_en, 1'b1);
        chk("add_acc", bus.acc, 8'hFF);
        @(negedge tclk);
        chk("add_done_pulse", bus.done, 1'b0);
        chk("add_busy_after", bus.busy, 1'b0);

        // LD 0x05, SUB 0x07 borrows; WB copies latch into acc
        issue(3'b100, 8'h05, 1'b0, 3'd0);
        issue(3'b001, 8'h07, 1'b0, 3'd0);
        chk("sub_latch", bus.latch, 8'hFE);
        chk("sub_c", bus.c, 1'b1);
        chk("sub_z", bus.z, 1'b0);
        issue(3'b111, 8'h00, 1'b0, 3'd0);
        chk("wb_acc", bus.acc, 8'hFE);
        chk("wb_c", bus.c, 1'b1);
        chk("wb_z", bus.z, 1'b0);
        chk("wb_latch", bus.latch, 8'hFE);
        chk("wb_oe", bus.dout_en, 1'b0);

        // NAND 0xFE,0x0F = 0xF1; ST copies acc to latch
        issue(3'b010, 8'h0F, 1'b0, 3'd0);
        chk("nand_latch", bus.latch, 8'hF1);
        chk("nand_c", bus.c, 1'b0);
        issue(3'b101, 8'h00, 1'b0, 3'd0);
        chk("st_dout", bus.dout, 8'hFE);
        chk("st_oe", bus.dout_en, 1'b1);

        // SHIFT right by 3 of 0x8D -> 0x11, last bit out = 1
        issue(3'b100, 8'h8D, 1'b0, 3'd0);
        issue(3'b011, 8'h00, 1'b1, 3'd3);
        chk("shr_busy", bus.busy, 1'b1);
        chk("shr_hold_latch", bus.latch, 8'hFE);
        n = 0;
        wait_done(n);
        chk("shr_cycles", n, 3);
        chk("shr_latch", bus.latch, 8'h11);
        chk("shr_c", bus.c, 1'b1);
        chk("shr_z", bus.z, 1'b0);
        chk("shr_busy_end", bus.busy, 1'b0);
        chk("shr_acc", bus.acc, 8'h8D);
        @(negedge tclk);
        chk("shr_done_pulse", bus.done, 1'b0);

        // SHIFT amt 0 passes acc through in one cycle
        issue(3'b011, 8'h00, 1'b1, 3'd0);
        chk("sh0_done", bus.done, 1'b1);
        chk("sh0_busy", bus.busy, 1'b0);
        chk("sh0_latch", bus.latch, 8'h8D);
        chk("sh0_c", bus.c, 1'b0);

        // SHIFT left by 2 of 0x8D -> 0x34, last bit out = 0
        issue(3'b011, 8'h00, 1'b0, 3'd2);
        n = 0;
        wait_done(n);
        chk("shl_cycles", n, 2);
        chk("shl_latch", bus.latch, 8'h34);
        chk("shl_c", bus.c, 1'b0);

        // MUL 0x10*0x20 = 0x200; a start during busy is ignored
        issue(3'b100, 8'h10, 1'b0, 3'd0);
        issue(3'b110, 8'h20, 1'b0, 3'd0);
        chk("mul_busy", bus.busy, 1'b1);
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.din   = 8'h55;
        @(negedge tclk);
        bus.start = 1'b0;
        n = 1;
        wait_done(n);
        chk("mul_cycles", n, 8);
        chk("mul_latch", bus.latch, 8'h00);
        chk("mul_c", bus.c, 1'b1);
        chk("mul_z", bus.z, 1'b1);
        chk("mul_acc", bus.acc, 8'h10);
        chk("mul_oe", bus.dout_en, 1'b1);

        // MUL 0x0F*0x11 = 0x00FF
        issue(3'b100, 8'h0F, 1'b0, 3'd0);
        issue(3'b110, 8'h11, 1'b0, 3'd0);
        n = 0;
        wait_done(n);
        chk("mul2_cycles", n, 8);
        chk("mul2_latch", bus.latch, 8'hFF);
        chk("mul2_c", bus.c, 1'b0);
        chk("mul2_z", bus.z, 1'b0);

        // Reset held two edges starting at EXEC cycle 4 of a MUL
        issue(3'b100, 8'h10, 1'b0, 3'd0);
        issue(3'b110, 8'h20, 1'b0, 3'd0);
        repeat (3) @(negedge tclk);
        reset = 1'b0;
        repeat (2) @(negedge tclk);
        reset = 1'b1;
        chk("mrst_acc", bus.acc, 8'h00);
        chk("mrst_latch", bus.latch, 8'h00);
        chk("mrst_c", bus.c, 1'b0);
        chk("mrst_z", bus.z, 1'b0);
        chk("mrst_busy", bus.busy, 1'b0);
        chk("mrst_oe", bus.dout_en, 1'b0);
        saw_done = bus.done;
        for (int i = 0; i < 10; i++) begin
            @(negedge tclk);
            saw_done = saw_done | bus.done;
        end
        chk("mrst_no_done", saw_done, 1'b0);

        // MUL disabled: op 110 is a one-cycle NOP after a back-to-back LD
        bus2.start = 1'b1;
        bus2.op    = 3'b100;
        bus2.din   = 8'h33;
        @(negedge tclk);
        bus2.op    = 3'b110;
        bus2.din   = 8'h02;
        @(negedge tclk);
        bus2.start = 1'b0;
        chk("nop_done", bus2.done, 1'b1);
        chk("nop_oe", bus2.dout_en, 1'b0);
        chk("nop_busy", bus2.busy, 1'b0);
        chk("nop_acc", bus2.acc, 8'h33);
        chk("nop_latch", bus2.latch, 8'h00);
        chk("nop_c", bus2.c, 1'b0);
        chk("nop_z", bus2.z, 1'b0);
        @(negedge tclk);
        chk("nop_busy_after", bus2.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
